// File: rtl/glitch_sweep_trigger_pkg.sv
// rtl/glitch_sweep_trigger_pkg.sv - shared state encoding and default sweep bounds
//
// Purpose: state encoding and default parameters for the glitch sequencer,
//          shared by the RTL and any host-side tooling that decodes state.
// Ports:   none (package).

package glitch_sweep_trigger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_PULSE   = 3'd3,
        ST_HOLDOFF = 3'd4
    } gst_state_e;

    localparam int DEF_CLK_HZ     = 25000000;
    localparam int DEF_DELAY_MIN  = 0;
    localparam int DEF_DELAY_MAX  = 255;
    localparam int DEF_DELAY_STEP = 1;
    localparam int DEF_WIDTH_MIN  = 1;
    localparam int DEF_WIDTH_MAX  = 4;

endpackage

// File: rtl/glitch_sweep_trigger_trig_sync.sv
// rtl/glitch_sweep_trigger_trig_sync.sv - trigger synchroniser and rising-edge detector
//
// Purpose: brings the asynchronous target TRIG GPIO into the clk_i domain through
//          two flops, then flags a 0->1 transition with a one-cycle pulse.
// Ports:
//   clk_i   in  system clock
//   rst_i   in  synchronous active-high reset (clears all flops)
//   trig_i  in  asynchronous trigger input
//   rise_o  out one-cycle pulse on a synchronised rising edge

module glitch_sweep_trigger_trig_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic trig_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= trig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/glitch_sweep_trigger.sv
// rtl/glitch_sweep_trigger.sv - power-glitch timing stage with automatic delay/width sweep
//
// Purpose: waits for a rising edge on the target trigger, counts cur_delay_o cycles,
//          drops power_en_o for cur_width_o cycles, holds off, then re-arms. Each
//          completed pulse steps the delay, wrapping into the next width, so repeated
//          encryptions walk the whole delay x width grid.
// Ports:
//   clk_i          in   system clock
//   rst_i          in   synchronous active-high reset
//   arm_i          in   level; 1 accepts triggers, 0 aborts to idle
//   trig_i         in   asynchronous target trigger
//   power_en_o     out  target supply enable, 0 while glitching
//   busy_o         out  1 in DELAY, PULSE or HOLDOFF
//   sweep_done_o   out  one-cycle pulse when the grid wraps
//   cur_delay_o    out  [15:0] delay for the next/ongoing attempt
//   cur_width_o    out  [7:0]  width for the next/ongoing attempt
//   attempts_o     out  [15:0] completed pulses, saturating

module glitch_sweep_trigger
    import glitch_sweep_trigger_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int DELAY_MIN  = DEF_DELAY_MIN,
    parameter int DELAY_MAX  = DEF_DELAY_MAX,
    parameter int DELAY_STEP = DEF_DELAY_STEP,
    parameter int WIDTH_MIN  = DEF_WIDTH_MIN,
    parameter int WIDTH_MAX  = DEF_WIDTH_MAX,
    parameter int HOLDOFF    = CLK_HZ / 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        arm_i,
    input  logic        trig_i,
    output logic        power_en_o,
    output logic        busy_o,
    output logic        sweep_done_o,
    output logic [15:0] cur_delay_o,
    output logic [7:0]  cur_width_o,
    output logic [15:0] attempts_o
);

    // Sweep arithmetic is done one bit wider than the registers so that a step
    // past the upper bound is detected instead of silently wrapping.
    localparam logic [15:0] DELAY_MIN_W    = 16'(DELAY_MIN);
    localparam logic [16:0] DELAY_MAX_W    = 17'(DELAY_MAX);
    localparam logic [16:0] DELAY_STEP_W   = 17'(DELAY_STEP);
    localparam logic [7:0]  WIDTH_MIN_W    = 8'(WIDTH_MIN);
    localparam logic [8:0]  WIDTH_MAX_W    = 9'(WIDTH_MAX);
    localparam logic [31:0] HOLDOFF_LAST_W = 32'(HOLDOFF - 1);

    gst_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] cur_delay_q, cur_delay_d;
    logic [7:0]  cur_width_q, cur_width_d;
    logic [15:0] attempts_q, attempts_d;
    logic        sweep_done_q, sweep_done_d;
    logic        power_en_q, power_en_d;
    logic        busy_q, busy_d;

    logic        rise;
    logic [16:0] delay_next;
    logic [8:0]  width_next;
    logic [31:0] width_last;

    glitch_sweep_trigger_trig_sync u_trig_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .trig_i (trig_i),
        .rise_o (rise)
    );

    assign delay_next = {1'b0, cur_delay_q} + DELAY_STEP_W;
    assign width_next = {1'b0, cur_width_q} + 9'd1;
    assign width_last = {24'd0, cur_width_q} - 32'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_delay_d  = cur_delay_q;
        cur_width_d  = cur_width_q;
        attempts_d   = attempts_q;
        sweep_done_d = 1'b0;

        if (!arm_i) begin
            // Abort leaves the sweep position untouched so the attempt is retried.
            state_d = ST_IDLE;
            cnt_d   = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                    cnt_d   = 32'd0;
                end
                ST_ARMED: begin
                    if (rise) begin
                        state_d = ST_DELAY;
                        cnt_d   = 32'd0;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == {16'd0, cur_delay_q}) begin
                        state_d = ST_PULSE;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == width_last) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = 32'd0;
                        if (attempts_q != 16'hFFFF) begin
                            attempts_d = attempts_q + 16'd1;
                        end
                        if (delay_next > DELAY_MAX_W) begin
                            cur_delay_d = DELAY_MIN_W;
                            if (width_next > WIDTH_MAX_W) begin
                                cur_width_d  = WIDTH_MIN_W;
                                sweep_done_d = 1'b1;
                            end else begin
                                cur_width_d = width_next[7:0];
                            end
                        end else begin
                            cur_delay_d = delay_next[15:0];
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_q == HOLDOFF_LAST_W) begin
                        state_d = ST_ARMED;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 32'd0;
                end
            endcase
        end

        // Outputs are registered from the next state so the supply switch never
        // sees decode glitches from a multi-bit state change.
        power_en_d = (state_d != ST_PULSE);
        busy_d     = (state_d == ST_DELAY) || (state_d == ST_PULSE) ||
                     (state_d == ST_HOLDOFF);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 32'd0;
            cur_delay_q  <= DELAY_MIN_W;
            cur_width_q  <= WIDTH_MIN_W;
            attempts_q   <= 16'd0;
            sweep_done_q <= 1'b0;
            power_en_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_delay_q  <= cur_delay_d;
            cur_width_q  <= cur_width_d;
            attempts_q   <= attempts_d;
            sweep_done_q <= sweep_done_d;
            power_en_q   <= power_en_d;
            busy_q       <= busy_d;
        end
    end

    assign power_en_o   = power_en_q;
    assign busy_o       = busy_q;
    assign sweep_done_o = sweep_done_q;
    assign cur_delay_o  = cur_delay_q;
    assign cur_width_o  = cur_width_q;
    assign attempts_o   = attempts_q;

endmodule
